rv_lsu: RTL
===========

// Module: rv_lsu
// PURPOSE
//  Load/store unit between the core's memory stage and rv_dmem.
//  Accepts one LB/LH/LW/LBU/LHU/SB/SH/SW request at a time over a valid/ready handshake.
//  Checks alignment and range, and drives rv_dmem's word port (comb read, sync write).
//  Sub-word stores use read-modify-write; loads are lane-extracted and sign/zero-extended.
//  Returns the result over rsp_valid/rsp_ready. Memory is little-endian.
// PARAMETERS
//  WORDS  1024          dmem depth in 32-bit words (must match rv_dmem)
//  BASE   32'h0000_1000 byte address of dmem word 0 (must match rv_dmem)
// PORTS
//  clk          in   1   clock, all state on posedge
//  rst_n        in   1   asynchronous active-low reset
//  req_valid    in   1   request present
//  req_ready    out  1   high only in IDLE
//  req_we       in   1   1=store, 0=load
//  req_size     in   2   0=byte, 1=half, 2=word, 3=illegal
//  req_unsigned in   1   loads only: 1=zero-extend, 0=sign-extend
//  req_addr     in   32  byte address
//  req_wdata    in   32  store data, right-aligned (byte in [7:0], half in [15:0])
//  rsp_valid    out  1   response present, held until rsp_ready
//  rsp_ready    in   1   consumer accepts response
//  rsp_rdata    out  32  extended load data; 0 for stores and faults
//  rsp_fault    out  1   misaligned, out-of-range or illegal size; no memory side effect
//  mem_we       out  1   to rv_dmem.we
//  mem_addr     out  32  to rv_dmem.addr, always word-aligned
//  mem_wdata    out  32  to rv_dmem.wdata
//  mem_rdata    in   32  from rv_dmem.rdata, combinational from mem_addr
// BEHAVIOUR
//  States: IDLE, LOAD, MERGE, WRITE, RESP.
//  Reset: state=IDLE; rsp_valid=0, rsp_fault=0, rsp_rdata=0; all latched request regs=0.
//    mem_we=0, mem_addr=BASE, mem_wdata=0.
//  Handshakes:
//    Request accepted on posedge with req_valid&req_ready; request fields latched.
//    req_ready=0 in every state except IDLE.
//    Response retires on posedge with rsp_valid&rsp_ready; RESP->IDLE.
//    rsp_* stable while rsp_valid&!rsp_ready.
//  Fault, evaluated at accept:
//    Conditions: size==3; half with addr[0]; word with addr[1:0]!=0;
//      addr<BASE; addr>=BASE+4*WORDS.
//    Action: IDLE->RESP with rsp_fault=1 and rsp_rdata=0. mem_we never asserted.
//  Load: IDLE->LOAD->RESP.
//    In LOAD: mem_addr={a[31:2],2'b00}; register extracted lane.
//      Byte lane = a[1:0]; half lane = a[1].
//    Extend per req_unsigned.
//  Word store: IDLE->WRITE->RESP. mem_we=1 for exactly the WRITE cycle; mem_wdata=req_wdata.
//  Sub-word store: IDLE->MERGE->WRITE->RESP.
//    MERGE: merged = mem_rdata with target lane replaced, held in a register.
//    WRITE: merged word is written.
//  Latency, request accept at T, rsp_valid first high at:
//    fault T+1; load T+2; SW T+2; SB/SH T+3.
//  mem_we decoded from state only (state==WRITE); never asserted outside WRITE.
//  mem_addr=BASE in IDLE/RESP.
//  rsp_valid is high only in RESP, so there are no back-to-back responses.
//    Max one request in flight.
//  Reset asserted mid-operation:
//    Immediate return to IDLE; outputs take reset values asynchronously.
//    Reset in MERGE or WRITE before the write edge loses the store entirely.
//    Memory is never partially merged.
//  req_* inputs are ignored outside IDLE; only the latched copy is used.
// STRUCTURE
//  Shared header rv_lsu_defs.vh:
//    SIZE_B/SIZE_H/SIZE_W encodings; state localparams.
//    Fault-cause encodings for later CSR use.
//  Sub-module rv_lsu_lane (combinational):
//    extract(word,off,size,uns)->32b; merge(word,data,off,size)->32b.
//  Top: FSM, request/response regs, range/alignment check.
// TESTING (dmem init: 0x1000=0x4000_0000, 0x1004=0x4040_0000, 0x1008=0)
//  1. LW 0x1004, rsp_ready=1 -> rsp_valid at T+2, rdata=0x4040_0000, fault=0.
//     LHU 0x1002 -> 0x0000_4000.
//  2. SB 0x80 @0x1008, then LB 0x1008 -> 0xFFFF_FF80; LBU 0x1008 -> 0x0000_0080.
//  3. SB 0xAB @0x1005:
//     mem_we=1 exactly one cycle (T+2), mem_addr=0x1004, mem_wdata=0x4040_AB00.
//     Later LW 0x1004 -> 0x4040_AB00.
//  4. LW 0x1002, SH 0x1001, LW 0x0FFC, LW 0x2000, size=3 each:
//     -> rsp_fault=1 at T+1, rdata=0, mem_we never high.
//  5. LW 0x1000 with rsp_ready low 3 cycles:
//     -> rsp_valid/rdata held at 0x4000_0000; req_ready=0.
//     New req_valid ignored until retire.
//  6. SH 0x1234 @0x1000, rst_n low during MERGE:
//     -> outputs reset immediately, no mem_we; LW 0x1000 afterwards -> 0x4000_0000.

Source files
------------

// File: rtl/rv_lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states, fault causes.
// Also holds the accept-time fault classifier used by the top.
package rv_lsu_pkg;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;
  localparam logic [1:0] SIZE_X = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_MERGE = 3'd2,
    ST_WRITE = 3'd3,
    ST_RESP  = 3'd4
  } lsu_state_t;

  // Cause codes kept distinct so a CSR can report them later.
  typedef enum logic [1:0] {
    FLT_NONE  = 2'd0,
    FLT_SIZE  = 2'd1,
    FLT_ALIGN = 2'd2,
    FLT_RANGE = 2'd3
  } lsu_fault_t;

  function automatic lsu_fault_t lsu_fault_cause(input logic [1:0] size,
                                                 input logic [31:0] addr,
                                                 input logic [31:0] base,
                                                 input logic [32:0] limit);
    lsu_fault_t c;
    c = FLT_NONE;
    if (size == SIZE_X) c = FLT_SIZE;
    else if ((size == SIZE_H && addr[0]) || (size == SIZE_W && addr[1:0] != 2'b00)) c = FLT_ALIGN;
    else if (addr < base || {1'b0, addr} >= limit) c = FLT_RANGE;
    return c;
  endfunction

endpackage

// File: rtl/rv_lsu_lane.sv
// Byte-lane helpers: extract a sign/zero-extended load value from a word, and
// merge right-aligned store data into the addressed lane of a word.
module rv_lsu_lane
  import rv_lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [31:0] data,
  input  logic [1:0]  off,
  input  logic [1:0]  size,
  input  logic        uns,
  output logic [31:0] extract,
  output logic [31:0] merged
);

  logic [4:0]  shamt;
  logic [31:0] shifted;
  logic [31:0] mask;

  always_comb begin
    shamt   = {off, 3'b000};
    shifted = word >> shamt;
    extract = word;
    mask    = 32'hFFFF_FFFF;
    case (size)
      SIZE_B: begin
        extract = uns ? {24'd0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
        mask    = 32'h0000_00FF << shamt;
      end
      SIZE_H: begin
        // Halves are aligned, so off[0] is zero and the same shift picks the lane.
        extract = uns ? {16'd0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
        mask    = 32'h0000_FFFF << shamt;
      end
      default: begin
        extract = word;
        mask    = 32'hFFFF_FFFF;
      end
    endcase
    merged = (word & ~mask) | ((data << shamt) & mask);
  end

endmodule

// File: rtl/rv_lsu.sv
// Load/store unit in front of rv_dmem: one request at a time, alignment/range
// checking, read-modify-write for sub-word stores, extended loads.
//
// Handshakes: a request transfers on a posedge where req_valid && req_ready
// (req_ready is high only in IDLE); a response transfers on a posedge where
// rsp_valid && rsp_ready, and rsp_* hold steady while rsp_valid && !rsp_ready.
module rv_lsu
  import rv_lsu_pkg::*;
#(
  parameter int          WORDS = 1024,
  parameter logic [31:0] BASE  = 32'h0000_1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_fault,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic [2:0]  dbg_state
);

  localparam logic [32:0] LIMIT = {1'b0, BASE} + 33'(WORDS) * 33'd4;

  lsu_state_t  state;
  logic        we_q;
  logic [1:0]  size_q;
  logic        uns_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] merged_q;
  logic [31:0] lane_extract;
  logic [31:0] lane_merged;
  lsu_fault_t  cause;

  assign cause = lsu_fault_cause(req_size, req_addr, BASE, LIMIT);

  rv_lsu_lane u_lane (
    .word    (mem_rdata),
    .data    (wdata_q),
    .off     (addr_q[1:0]),
    .size    (size_q),
    .uns     (uns_q),
    .extract (lane_extract),
    .merged  (lane_merged)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      we_q      <= 1'b0;
      size_q    <= 2'd0;
      uns_q     <= 1'b0;
      addr_q    <= 32'd0;
      wdata_q   <= 32'd0;
      merged_q  <= 32'd0;
      rsp_rdata <= 32'd0;
      rsp_fault <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            we_q      <= req_we;
            size_q    <= req_size;
            uns_q     <= req_unsigned;
            addr_q    <= req_addr;
            wdata_q   <= req_wdata;
            rsp_rdata <= 32'd0;
            rsp_fault <= (cause != FLT_NONE);
            if (cause != FLT_NONE)  state <= ST_RESP;
            else if (!req_we)       state <= ST_LOAD;
            else if (req_size == SIZE_W) state <= ST_WRITE;
            else                    state <= ST_MERGE;
          end
        end
        ST_LOAD: begin
          rsp_rdata <= lane_extract;
          state     <= ST_RESP;
        end
        ST_MERGE: begin
          merged_q <= lane_merged;
          state    <= ST_WRITE;
        end
        ST_WRITE: state <= ST_RESP;
        ST_RESP:  if (rsp_ready) state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  // Memory port is decoded from state alone so a reset kills any pending write.
  always_comb begin
    req_ready = (state == ST_IDLE);
    rsp_valid = (state == ST_RESP);
    mem_we    = (state == ST_WRITE);
    mem_addr  = BASE;
    mem_wdata = 32'd0;
    if (state == ST_LOAD || state == ST_MERGE || state == ST_WRITE)
      mem_addr = {addr_q[31:2], 2'b00};
    if (state == ST_WRITE)
      mem_wdata = (size_q == SIZE_W) ? wdata_q : merged_q;
    dbg_state = state;
  end

  logic unused_ok;
  assign unused_ok = we_q;

endmodule
